// File: rtl/cp_remover_pkg.sv
// rtl/cp_remover_pkg.sv - shared OFDM cyclic-prefix definitions
//
// Purpose: state encoding and default dimensions shared by the receive-side
//          prefix remover and the transmit-side prefix inserter, so both
//          ends of the link agree on one definition.
// Contents: DEF_DATA_WIDTH, DEF_SYM_LEN, DEF_CP_LEN, cp_rx_state_t
package cp_remover_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_SYM_LEN    = 8;
   localparam int DEF_CP_LEN     = 2;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      SKIP     = 2'd1,
      COLLECT  = 2'd2,
      HOLD     = 2'd3
   } cp_rx_state_t;

endpackage

// File: rtl/cp_remover.sv
// rtl/cp_remover.sv - receive cyclic prefix removal and serial-to-parallel packing
//
// Purpose: drops the first CP_LEN samples of each symbol (start marked by
//          i_in_sof) and packs the following SYM_LEN samples into a parallel
//          vector, presented with a valid/ready handshake.
// Ports:
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-high reset
//   i_in_data    serial sample
//   i_in_valid   sample valid
//   i_in_sof     beat is sample 0 (first prefix sample) of a symbol
//   o_in_ready   beat accepted when i_in_valid && o_in_ready
//   o_out_data   parallel symbol body, element k = body sample k
//   o_out_valid  o_out_data holds a complete symbol
//   i_out_ready  downstream accepts when o_out_valid && i_out_ready
//   o_sync_err   one-cycle pulse after an i_in_sof seen mid-symbol
module cp_remover
   import cp_remover_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int SYM_LEN    = DEF_SYM_LEN,
   parameter int CP_LEN     = DEF_CP_LEN
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic [DATA_WIDTH-1:0]               i_in_data,
   input  logic                                i_in_valid,
   input  logic                                i_in_sof,
   output logic                                o_in_ready,
   output logic [SYM_LEN-1:0][DATA_WIDTH-1:0]  o_out_data,
   output logic                                o_out_valid,
   input  logic                                i_out_ready,
   output logic                                o_sync_err
);

   localparam int CW = $clog2(SYM_LEN) + 1;
   localparam int IW = $clog2(SYM_LEN);

   cp_rx_state_t    r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_sync_err;
   logic            w_accept;

   // Ready is held low while reset is asserted, independent of the state.
   assign o_in_ready  = !i_rst && (r_state != HOLD);
   assign o_out_valid = (r_state == HOLD);
   assign o_sync_err  = r_sync_err;
   assign w_accept    = i_in_valid && o_in_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= WAIT_SOF;
         r_cnt      <= '0;
         r_sync_err <= 1'b0;
         o_out_data <= '0;
      end else begin
         r_sync_err <= 1'b0;
         case (r_state)
            HOLD: begin
               if (i_out_ready) begin
                  r_state <= WAIT_SOF;
               end
            end
            default: begin
               if (w_accept) begin
                  if (i_in_sof) begin
                     // A marker always restarts the symbol; outside WAIT_SOF
                     // the partial symbol is abandoned and flagged.
                     r_sync_err <= (r_state != WAIT_SOF);
                     if (CP_LEN == 1) begin
                        r_state <= COLLECT;
                        r_cnt   <= '0;
                     end else begin
                        r_state <= SKIP;
                        r_cnt   <= CW'(1);
                     end
                  end else begin
                     case (r_state)
                        SKIP: begin
                           if (r_cnt == CW'(CP_LEN - 1)) begin
                              r_state <= COLLECT;
                              r_cnt   <= '0;
                           end else begin
                              r_cnt <= r_cnt + CW'(1);
                           end
                        end
                        COLLECT: begin
                           o_out_data[r_cnt[IW-1:0]] <= i_in_data;
                           r_cnt <= r_cnt + CW'(1);
                           if (r_cnt == CW'(SYM_LEN - 1)) begin
                              r_state <= HOLD;
                           end
                        end
                        default: begin
                           // WAIT_SOF: beats before a marker are dropped.
                        end
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule
